// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt arbiter.
// Optional rotating priority is enabled with the VIC_ROUNDROBIN_EN macro.
package vic_pkg;

    localparam int          VIC_NSRC_MAX = 16;
    localparam int          VIC_IDX_W    = 4;
    localparam logic [15:0] VIC_SPUR_VEC = 16'o000004;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_REL  = 2'd2
    } vic_state_e;

    // Rotation base that follows a delivery from source idx.
    function automatic logic [VIC_IDX_W-1:0] next_base(input logic [VIC_IDX_W-1:0] idx,
                                                      input int nsrc);
        if (int'(idx) + 1 >= nsrc)
            return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Combinational priority encoder: the search starts at i_base and wraps, so a
// zero base gives plain fixed priority with bit 0 highest.
module vic_prio_enc
    import vic_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]      i_req,
    input  logic [VIC_IDX_W-1:0] i_base,
    output logic                 o_any,
    output logic [VIC_IDX_W-1:0] o_idx
);

    logic [NSRC-1:0] w_rot;
    int              w_sum;

    // Rotate so that the base source lands at bit 0 of w_rot.
    assign w_rot = NSRC'({i_req, i_req} >> i_base);

    // NOTE: every output gets a default before the loop, otherwise the
    // paths where no bit matches would infer latches.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_sum = 0;
        for (int k = 0; k < NSRC; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_sum = int'(i_base) + k;
                if (w_sum >= NSRC)
                    w_sum = w_sum - NSRC;
                o_idx = VIC_IDX_W'(w_sum);
            end
        end
    end

endmodule

// File: rtl/vic_arbiter.sv
// Vectored interrupt arbiter driving the CPU virq/ivec/istb/iack bus.
// Define VIC_ROUNDROBIN_EN for rotating priority; fixed priority otherwise.
module vic_arbiter
    import vic_pkg::*;
#(
    parameter int          NSRC     = 8,
    parameter logic [15:0] SPUR_VEC = VIC_SPUR_VEC
) (
    input  logic               clk_p,
    input  logic               rst_n,
    input  logic [NSRC-1:0]    ireq,
    input  logic [NSRC*16-1:0] ivec_tab,
    output logic               virq,
    input  logic               istb,
    output logic [15:0]        ivec,
    output logic               iack,
    output logic [NSRC-1:0]    dev_ack
);

    vic_state_e           r_state;
    logic                 r_virq;
    logic [15:0]          r_ivec;
    logic                 r_iack;
    logic [NSRC-1:0]      r_dev_ack;

    logic [VIC_IDX_W-1:0] w_base;
    logic                 w_any;
    logic [VIC_IDX_W-1:0] w_idx;
    logic [15:0]          w_vec;
    logic [NSRC-1:0]      w_onehot;

    vic_prio_enc #(.NSRC(NSRC)) u_prio_enc (
        .i_req  (ireq),
        .i_base (w_base),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    always_comb begin
        w_vec    = '0;
        w_onehot = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (w_idx == VIC_IDX_W'(k)) begin
                w_vec       = ivec_tab[16*k +: 16];
                w_onehot[k] = w_any;
            end
        end
    end

`ifdef VIC_ROUNDROBIN_EN
    logic [VIC_IDX_W-1:0] r_base;

    // Spurious cycles (no request) leave the base where it was.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n)
            r_base <= '0;
        else if (r_state == ST_IDLE && istb && w_any)
            r_base <= next_base(w_idx, NSRC);
    end

    assign w_base = r_base;
`else
    assign w_base = '0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_virq    <= 1'b0;
            r_ivec    <= '0;
            r_iack    <= 1'b0;
            r_dev_ack <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_virq <= |ireq;
                    if (istb) begin
                        r_ivec    <= w_any ? w_vec : SPUR_VEC;
                        r_iack    <= 1'b1;
                        r_dev_ack <= w_onehot;
                        r_state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_dev_ack <= '0;
                    r_virq    <= 1'b0;
                    r_state   <= ST_REL;
                end
                ST_REL: begin
                    r_virq <= 1'b0;
                    if (!istb) begin
                        r_iack  <= 1'b0;
                        r_ivec  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign virq    = r_virq;
    assign ivec    = r_ivec;
    assign iack    = r_iack;
    assign dev_ack = r_dev_ack;

endmodule
